// File: rtl/trdb_branch_map_gen_pkg.sv
// Shared trace constants and types for the branch-map generator and its optional
// bimodal predictor (enabled by TRDB_BRANCH_PREDICTOR_EN).
package trdb_branch_map_gen_pkg;

    localparam int BRANCH_MAP_LEN     = 31;
    localparam int BRANCH_COUNT_LEN   = $clog2(BRANCH_MAP_LEN + 1);
    localparam int BP_ENTRIES_DEFAULT = 64;
    localparam int PBC_LEN_DEFAULT    = 16;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_t;

    // Two-bit saturating counter step toward the observed outcome.
    function automatic bp_ctr_t bp_ctr_update(input bp_ctr_t c, input logic taken);
        if (taken) begin
            return (c == ST) ? ST : bp_ctr_t'(c + 2'd1);
        end
        return (c == SNT) ? SNT : bp_ctr_t'(c - 2'd1);
    endfunction

endpackage

// File: rtl/trdb_branch_map_gen_bimodal.sv
// Bimodal branch predictor: table of 2-bit counters indexed by the branch address.
// Only present when TRDB_BRANCH_PREDICTOR_EN is defined.
`ifdef TRDB_BRANCH_PREDICTOR_EN
module trdb_bimodal_predictor
    import trdb_branch_map_gen_pkg::*;
#(
    parameter int BP_ENTRIES = BP_ENTRIES_DEFAULT,
    parameter int XLEN       = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic            taken_i,
    input  logic [XLEN-1:0] iaddr_i,
    output logic            pred_o
);

    localparam int IDX_W = $clog2(BP_ENTRIES);

    bp_ctr_t          tbl_q [BP_ENTRIES];
    bp_ctr_t          cur;
    logic [IDX_W-1:0] idx;
    logic             unused_addr;

    // Bit 0 is skipped: branch addresses are at least halfword aligned.
    assign idx         = iaddr_i[IDX_W:1];
    assign cur         = tbl_q[idx];
    assign pred_o      = cur[1];
    assign unused_addr = ^{iaddr_i[XLEN-1:IDX_W+1], iaddr_i[0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < BP_ENTRIES; i++) begin
                tbl_q[i] <= WNT;
            end
        end else if (valid_i) begin
            tbl_q[idx] <= bp_ctr_update(cur, taken_i);
        end
    end

endmodule
`endif

// File: rtl/trdb_branch_map_gen.sv
// Branch-map accumulator for the trace encoder: records not-taken bits in retirement
// order with a count and full/empty/overflow flags. TRDB_BRANCH_PREDICTOR_EN adds a
// bimodal predictor that folds correctly predicted branches into a counter (pbc_o).
module trdb_branch_map_gen
    import trdb_branch_map_gen_pkg::*;
#(
    parameter int MAP_LEN    = BRANCH_MAP_LEN,
    parameter int CNT_LEN    = $clog2(MAP_LEN + 1),
    parameter int BP_ENTRIES = BP_ENTRIES_DEFAULT,
    parameter int PBC_LEN    = PBC_LEN_DEFAULT,
    parameter int XLEN       = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    input  logic               taken_i,
    input  logic               flush_i,
`ifdef TRDB_BRANCH_PREDICTOR_EN
    input  logic [XLEN-1:0]    iaddr_i,
    output logic [PBC_LEN-1:0] pbc_o,
    output logic               pbc_valid_o,
`endif
    output logic [MAP_LEN-1:0] map_o,
    output logic [CNT_LEN-1:0] branches_o,
    output logic               is_full_o,
    output logic               is_empty_o,
    output logic               overflow_o
);

    logic [MAP_LEN-1:0] map_q, map_d, base_map;
    logic [CNT_LEN-1:0] cnt_q, cnt_d, base_cnt;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               ovf_q, ovf_d;
    logic               enter_map;

`ifdef TRDB_BRANCH_PREDICTOR_EN
    logic               pred;
    logic               map_empty;
    logic [PBC_LEN-1:0] pbc_q, pbc_d, pbc_base;
    logic               pbcv_q, pbcv_d;

    trdb_bimodal_predictor #(
        .BP_ENTRIES (BP_ENTRIES),
        .XLEN       (XLEN)
    ) u_bp (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .taken_i (taken_i),
        .iaddr_i (iaddr_i),
        .pred_o  (pred)
    );

    // A flush empties the map before the incoming branch is considered.
    assign map_empty = flush_i || empty_q;

    always_comb begin
        // A pulse issued last cycle means the reported count has been consumed.
        pbc_base  = pbcv_q ? '0 : pbc_q;
        pbc_d     = pbc_base;
        pbcv_d    = 1'b0;
        enter_map = 1'b1;
        if (valid_i && map_empty) begin
            if (pred == taken_i) begin
                enter_map = 1'b0;
                pbc_d     = pbc_base + 1'b1;
                pbcv_d    = &pbc_d;
            end else begin
                pbcv_d    = (pbc_base != '0);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pbc_q  <= '0;
            pbcv_q <= 1'b0;
        end else begin
            pbc_q  <= pbc_d;
            pbcv_q <= pbcv_d;
        end
    end

    assign pbc_o       = pbc_q;
    assign pbc_valid_o = pbcv_q;
`else
    logic [31:0] unused_cfg;

    assign unused_cfg = 32'(XLEN + BP_ENTRIES + PBC_LEN);
    assign enter_map  = 1'b1;
`endif

    always_comb begin
        base_map = flush_i ? '0 : map_q;
        base_cnt = flush_i ? '0 : cnt_q;
        map_d    = base_map;
        cnt_d    = base_cnt;
        ovf_d    = 1'b0;
        if (valid_i && enter_map) begin
            // After a flush there is always room, so full_q only guards the no-flush case.
            if (flush_i || !full_q) begin
                for (int i = 0; i < MAP_LEN; i++) begin
                    if (base_cnt == CNT_LEN'(i)) begin
                        map_d[i] = ~taken_i;
                    end
                end
                cnt_d = base_cnt + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
        full_d  = (cnt_d == CNT_LEN'(MAP_LEN));
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            map_q   <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            map_q   <= map_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ovf_q   <= ovf_d;
        end
    end

    assign map_o      = map_q;
    assign branches_o = cnt_q;
    assign is_full_o  = full_q;
    assign is_empty_o = empty_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_trdb_branch_map_gen.sv
// Self-checking bench for trdb_branch_map_gen; the predictor scenarios are built
// when TRDB_BRANCH_PREDICTOR_EN is defined.
module tb_trdb_branch_map_gen;
    import trdb_branch_map_gen_pkg::*;

    localparam int MAP_LEN    = 31;
    localparam int CNT_LEN    = $clog2(MAP_LEN + 1);
    localparam int BP_ENTRIES = 64;
    localparam int PBC_LEN    = 4;
    localparam int XLEN       = 32;

    logic               clk = 1'b0;
    logic               rst_i = 1'b1;
    logic               valid_i = 1'b0;
    logic               taken_i = 1'b0;
    logic               flush_i = 1'b0;
    logic [MAP_LEN-1:0] map_o;
    logic [CNT_LEN-1:0] branches_o;
    logic               is_full_o;
    logic               is_empty_o;
    logic               overflow_o;

    int checks   = 0;
    int failures = 0;

    // Reference: queue of not-taken bits, oldest first.
    bit q[$];
    bit exp_ovf;

`ifdef TRDB_BRANCH_PREDICTOR_EN
    logic [XLEN-1:0]    iaddr_i = '0;
    logic [PBC_LEN-1:0] pbc_o;
    logic               pbc_valid_o;
    int                 tbl[BP_ENTRIES];
    int                 exp_pbc;
    bit                 exp_pbcv;
`endif

    always #5 clk = ~clk;

    trdb_branch_map_gen #(
        .MAP_LEN    (MAP_LEN),
        .CNT_LEN    (CNT_LEN),
        .BP_ENTRIES (BP_ENTRIES),
        .PBC_LEN    (PBC_LEN),
        .XLEN       (XLEN)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .taken_i     (taken_i),
        .flush_i     (flush_i),
`ifdef TRDB_BRANCH_PREDICTOR_EN
        .iaddr_i     (iaddr_i),
        .pbc_o       (pbc_o),
        .pbc_valid_o (pbc_valid_o),
`endif
        .map_o       (map_o),
        .branches_o  (branches_o),
        .is_full_o   (is_full_o),
        .is_empty_o  (is_empty_o),
        .overflow_o  (overflow_o)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    function automatic logic [MAP_LEN-1:0] exp_map();
        logic [MAP_LEN-1:0] r = '0;
        for (int i = 0; i < q.size(); i++) r[i] = q[i];
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        exp_ovf = 1'b0;
`ifdef TRDB_BRANCH_PREDICTOR_EN
        for (int i = 0; i < BP_ENTRIES; i++) tbl[i] = 1;
        exp_pbc  = 0;
        exp_pbcv = 1'b0;
`endif
    endtask

    task automatic model_step(input bit v, input bit t, input bit f, input logic [31:0] a);
        bit fold = 1'b0;
`ifdef TRDB_BRANCH_PREDICTOR_EN
        int  base = exp_pbcv ? 0 : exp_pbc;
        int  idx  = int'((a >> 1) % BP_ENTRIES);
        bit  pred;
        exp_pbcv = 1'b0;
`endif
        exp_ovf = 1'b0;
        if (f) q.delete();
        if (v) begin
`ifdef TRDB_BRANCH_PREDICTOR_EN
            pred = (tbl[idx] >= 2);
            if (t) tbl[idx] = (tbl[idx] == 3) ? 3 : tbl[idx] + 1;
            else   tbl[idx] = (tbl[idx] == 0) ? 0 : tbl[idx] - 1;
            if (q.size() == 0 && pred == t) begin
                fold = 1'b1;
                base++;
                if (base == (2 ** PBC_LEN) - 1) exp_pbcv = 1'b1;
            end else if (q.size() == 0 && base > 0) begin
                exp_pbcv = 1'b1;
            end
`endif
            if (!fold) begin
                if (q.size() < MAP_LEN) q.push_back(!t);
                else exp_ovf = 1'b1;
            end
        end
`ifdef TRDB_BRANCH_PREDICTOR_EN
        exp_pbc = base;
`else
        if (a[0] && fold) exp_ovf = 1'b1;
`endif
    endtask

    task automatic step(input bit v, input bit t, input bit f, input logic [31:0] a);
        valid_i = v;
        taken_i = t;
        flush_i = f;
`ifdef TRDB_BRANCH_PREDICTOR_EN
        iaddr_i = a;
`endif
        model_step(v, t, f, a);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        taken_i = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic apply_reset();
        rst_i   = 1'b1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (map_o !== '0) begin failures++; $display("FAIL reset_map got=%h exp=0", map_o); end
        checks++; if (branches_o !== '0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", branches_o); end
        checks++; if (is_full_o !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", is_full_o); end
        checks++; if (is_empty_o !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", is_empty_o); end
        checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow_o); end
`ifdef TRDB_BRANCH_PREDICTOR_EN
        checks++; if (pbc_o !== '0 || pbc_valid_o !== 1'b0) begin failures++; $display("FAIL reset_pbc got=%0d/%b exp=0/0", pbc_o, pbc_valid_o); end
`endif
    endtask

    task automatic test_tnt();
        apply_reset();
        step(1, 1, 0, 32'h200);
        step(1, 0, 0, 32'h200);
        step(1, 1, 0, 32'h200);
        checks++; if (map_o !== MAP_LEN'(3'b010)) begin failures++; $display("FAIL tnt_map got=%h exp=2", map_o); end
        checks++; if (branches_o !== CNT_LEN'(3)) begin failures++; $display("FAIL tnt_cnt got=%0d exp=3", branches_o); end
        checks++; if (is_empty_o !== 1'b0) begin failures++; $display("FAIL tnt_empty got=%b exp=0", is_empty_o); end
    endtask

    task automatic test_fill_overflow();
        logic [MAP_LEN-1:0] snap;
        apply_reset();
        for (int i = 0; i < MAP_LEN; i++) step(1, 0, 0, 32'h300 + 32'(4 * i));
`ifndef TRDB_BRANCH_PREDICTOR_EN
        checks++; if (map_o !== '1) begin failures++; $display("FAIL fill_ones got=%h exp=all-ones", map_o); end
`endif
        checks++; if (map_o !== exp_map()) begin failures++; $display("FAIL fill_map got=%h exp=%h", map_o, exp_map()); end
        checks++; if (is_full_o !== (q.size() == MAP_LEN)) begin failures++; $display("FAIL fill_full got=%b exp=%b", is_full_o, q.size() == MAP_LEN); end
        // Top up to full under either build, then push one more.
        while (q.size() < MAP_LEN) step(1, 1, 0, 32'h300);
        checks++; if (is_full_o !== 1'b1) begin failures++; $display("FAIL full_flag got=%b exp=1", is_full_o); end
        snap = map_o;
        step(1, 1, 0, 32'h300);
        checks++; if (overflow_o !== 1'b1) begin failures++; $display("FAIL ovf_pulse got=%b exp=1", overflow_o); end
        checks++; if (map_o !== snap || branches_o !== CNT_LEN'(MAP_LEN)) begin failures++; $display("FAIL ovf_hold map=%h cnt=%0d exp=%h/%0d", map_o, branches_o, snap, MAP_LEN); end
        step(0, 0, 0, 32'h300);
        checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL ovf_once got=%b exp=0", overflow_o); end
    endtask

    task automatic test_flush_valid();
        step(1, 1, 1, 32'h300);
        checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL fv_ovf got=%b exp=0", overflow_o); end
        checks++; if (branches_o !== CNT_LEN'(q.size()) || map_o !== exp_map()) begin failures++; $display("FAIL fv_state cnt=%0d map=%h exp=%0d/%h", branches_o, map_o, q.size(), exp_map()); end
`ifndef TRDB_BRANCH_PREDICTOR_EN
        checks++; if (branches_o !== CNT_LEN'(1) || map_o !== '0) begin failures++; $display("FAIL fv_const cnt=%0d map=%h exp=1/0", branches_o, map_o); end
`endif
        step(0, 0, 1, 32'h0);
        checks++; if (branches_o !== '0 || is_empty_o !== 1'b1 || map_o !== '0) begin failures++; $display("FAIL flush_only cnt=%0d empty=%b map=%h exp=0/1/0", branches_o, is_empty_o, map_o); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 5; i++) step(1, 1'($urandom_range(0, 1)), 0, 32'h400 + 32'(4 * i));
        rst_i   = 1'b1;
        valid_i = 1'b1;
        taken_i = 1'b0;
        @(posedge clk);
        #1;
        rst_i   = 1'b0;
        valid_i = 1'b0;
        model_reset();
        checks++; if (map_o !== '0 || branches_o !== '0 || is_full_o !== 1'b0 || is_empty_o !== 1'b1 || overflow_o !== 1'b0) begin
            failures++; $display("FAIL mid_reset map=%h cnt=%0d full=%b empty=%b ovf=%b exp=0/0/0/1/0", map_o, branches_o, is_full_o, is_empty_o, overflow_o);
        end
        for (int i = 5; i < 10; i++) step(1, 1'($urandom_range(0, 1)), 0, 32'h400 + 32'(4 * i));
        checks++; if (map_o !== exp_map() || branches_o !== CNT_LEN'(q.size())) begin failures++; $display("FAIL post_reset map=%h cnt=%0d exp=%h/%0d", map_o, branches_o, exp_map(), q.size()); end
    endtask

    task automatic test_random();
        bit v, t, f;
        logic [31:0] a;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 99) < 75);
            t = 1'($urandom_range(0, 1));
            f = ($urandom_range(0, 99) < (((i / 100) % 2) ? 2 : 15));
            a = 32'h1000 + 32'(4 * $urandom_range(0, 3));
            step(v, t, f, a);
            checks++; if (map_o !== exp_map()) begin failures++; $display("FAIL rand_map i=%0d got=%h exp=%h", i, map_o, exp_map()); end
            checks++; if (branches_o !== CNT_LEN'(q.size())) begin failures++; $display("FAIL rand_cnt i=%0d got=%0d exp=%0d", i, branches_o, q.size()); end
            checks++; if (is_full_o !== (q.size() == MAP_LEN) || is_empty_o !== (q.size() == 0)) begin failures++; $display("FAIL rand_flags i=%0d full=%b empty=%b size=%0d", i, is_full_o, is_empty_o, q.size()); end
            checks++; if (overflow_o !== exp_ovf) begin failures++; $display("FAIL rand_ovf i=%0d got=%b exp=%b", i, overflow_o, exp_ovf); end
`ifdef TRDB_BRANCH_PREDICTOR_EN
            checks++; if (pbc_o !== PBC_LEN'(exp_pbc) || pbc_valid_o !== exp_pbcv) begin failures++; $display("FAIL rand_pbc i=%0d got=%0d/%b exp=%0d/%b", i, pbc_o, pbc_valid_o, exp_pbc, exp_pbcv); end
`endif
        end
    endtask

`ifdef TRDB_BRANCH_PREDICTOR_EN
    task automatic test_pbc_basic();
        apply_reset();
        for (int i = 1; i <= 5; i++) begin
            step(1, 0, 0, 32'h40);
            checks++; if (pbc_o !== PBC_LEN'(i) || pbc_valid_o !== 1'b0 || is_empty_o !== 1'b1) begin failures++; $display("FAIL pbc_count i=%0d got=%0d/%b empty=%b", i, pbc_o, pbc_valid_o, is_empty_o); end
        end
        step(1, 1, 0, 32'h40);
        checks++; if (pbc_valid_o !== 1'b1 || pbc_o !== PBC_LEN'(5)) begin failures++; $display("FAIL pbc_final got=%0d/%b exp=5/1", pbc_o, pbc_valid_o); end
        checks++; if (map_o[0] !== 1'b0 || branches_o !== CNT_LEN'(1)) begin failures++; $display("FAIL pbc_map bit0=%b cnt=%0d exp=0/1", map_o[0], branches_o); end
        step(0, 0, 0, 32'h40);
        checks++; if (pbc_o !== '0 || pbc_valid_o !== 1'b0) begin failures++; $display("FAIL pbc_clear got=%0d/%b exp=0/0", pbc_o, pbc_valid_o); end
    endtask

    task automatic test_pbc_saturate();
        apply_reset();
        for (int i = 0; i < 15; i++) step(1, 0, 0, 32'h80);
        checks++; if (pbc_o !== 4'hF || pbc_valid_o !== 1'b1) begin failures++; $display("FAIL pbc_sat got=%0d/%b exp=15/1", pbc_o, pbc_valid_o); end
        step(0, 0, 0, 32'h80);
        checks++; if (pbc_o !== 4'h0 || pbc_valid_o !== 1'b0) begin failures++; $display("FAIL pbc_restart got=%0d/%b exp=0/0", pbc_o, pbc_valid_o); end
        step(1, 0, 0, 32'h80);
        checks++; if (pbc_o !== 4'h1 || is_empty_o !== 1'b1) begin failures++; $display("FAIL pbc_after got=%0d empty=%b exp=1/1", pbc_o, is_empty_o); end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_tnt();
        test_fill_overflow();
        test_flush_valid();
        test_reset_mid();
        test_random();
`ifdef TRDB_BRANCH_PREDICTOR_EN
        test_pbc_basic();
        test_pbc_saturate();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
